mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Port list SHALL be: name  direction  width  meaning (clock and reset first).
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  instruction-fetch read request
- if_addr  in  8  fetch address
- ls_req  in  1  load/store request
- ls_we  in  1  load/store write enable (1 = store)
- ls_addr  in  8  load/store address
- ls_wdata  in  16  store data
- dbg_req  in  1  debug/loader request
- dbg_we  in  1  debug write enable
- dbg_addr  in  8  debug address
- dbg_wdata  in  16  debug write data
- ram_rdata  in  16  RAM read data, valid one cycle after ram_en with ram_we = 0
- if_gnt, ls_gnt, dbg_gnt  out  1 each  one-cycle grant pulse
- if_rvalid, ls_rvalid, dbg_rvalid  out  1 each  one-cycle read-data-valid pulse
- rdata  out  16  registered read data, shared by all requesters
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  8  RAM address
- ram_wdata  out  16  RAM write data
- busy  out  1  high whenever state is not IDLE

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS, READ.
REQ-004 In IDLE, with any request high, the arbiter SHALL pick a winner, register its we/addr/wdata, and enter ACCESS on the next edge; with no request it SHALL stay in IDLE.
REQ-005 Priority: dbg_req SHALL always win; between if_req and ls_req, a round-robin pointer SHALL favour the requester not served last.
REQ-006 The round-robin pointer SHALL update only when if or ls is granted, not on a dbg grant.
REQ-007 In ACCESS, the arbiter SHALL assert ram_en = 1, drive ram_we/ram_addr/ram_wdata from the registered values, and pulse the winner's gnt for exactly this cycle.
REQ-008 From ACCESS, a write SHALL return to IDLE; a read SHALL go to READ.
REQ-009 In READ, the arbiter SHALL capture ram_rdata into rdata, pulse the winner's rvalid for exactly one cycle (concurrent with rdata valid), then return to IDLE.
REQ-010 if-port accesses SHALL always be reads; ram_we SHALL be 0 for an if grant.
REQ-011 Latency: a read request sampled in IDLE at cycle N SHALL give gnt at N+1 and rvalid/rdata at N+2; a write SHALL give gnt at N+1 with the RAM written on that edge.
REQ-012 A requester SHALL hold req and its fields until its gnt; a req dropped before selection in IDLE SHALL be ignored, and inputs changing after selection SHALL NOT affect the access.
REQ-013 Throughput: at most one access per 2 cycles (write) or 3 cycles (read); back-to-back requests SHALL be re-arbitrated in every IDLE.
REQ-014 Outside ACCESS, ram_en and ram_we SHALL be 0; ram_addr/ram_wdata SHALL hold their last values.
REQ-015 rdata SHALL hold its last captured value until the next READ state.
REQ-016 At most one gnt and at most one rvalid SHALL be high in any cycle.
REQ-017 Continuous if_req and ls_req SHALL alternate grants (no starvation); continuous dbg_req SHALL starve both, and this is intended.

Reset
REQ-018 When rst = 1 at an edge: state SHALL go to IDLE; all gnt, rvalid, ram_en, ram_we and busy SHALL be 0; rdata, ram_addr and ram_wdata SHALL be 0; the round-robin pointer SHALL favour if.
REQ-019 Reset during ACCESS or READ SHALL abort the transaction; no rvalid SHALL be issued for it afterward.

Verification
REQ-020 Single fetch: if_req=1, if_addr=0x10, RAM[0x10]=0xA5C3 -> if_gnt at N+1 with ram_en=1, ram_addr=0x10, ram_we=0; if_rvalid=1, rdata=0xA5C3 at N+2; busy high for 2 cycles.
REQ-021 Store: ls_req=1, ls_we=1, ls_addr=0x20, ls_wdata=0x1234 -> ls_gnt with ram_we=1, ram_wdata=0x1234 at N+1; IDLE at N+2; no rvalid.
REQ-022 Contention: if_req and ls_req held high for 6 grants after reset -> grant order if, ls, if, ls, if, ls.
REQ-023 Debug priority: dbg_req, if_req and ls_req all high -> dbg granted first; then if/ls alternation resumes from the pre-dbg pointer.
REQ-024 Reset mid-read: rst=1 in the ACCESS cycle of an ls read -> next cycle IDLE, all outputs 0, and no ls_rvalid ever for that access.

Source files
------------

// File: rtl/mem_arbiter.sv
// Three-requester single-port RAM arbiter: debug has absolute priority, fetch and
// load/store share round-robin. One access in flight; reads take an extra READ cycle.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [7:0]  if_addr,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [7:0]  ls_addr,
   input  logic [15:0] ls_wdata,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [7:0]  dbg_addr,
   input  logic [15:0] dbg_wdata,
   input  logic [15:0] ram_rdata,
   output logic        if_gnt,
   output logic        ls_gnt,
   output logic        dbg_gnt,
   output logic        if_rvalid,
   output logic        ls_rvalid,
   output logic        dbg_rvalid,
   output logic [15:0] rdata,
   output logic        ram_en,
   output logic        ram_we,
   output logic [7:0]  ram_addr,
   output logic [15:0] ram_wdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, READ} state_t;

   state_t      state_reg;
   logic [2:0]  owner_reg;      // one-hot {dbg, ls, if}
   logic [2:0]  gnt_reg;
   logic [2:0]  rvalid_reg;
   logic        rr_ls_reg;      // 1: ls wins an if/ls tie
   logic        ram_en_reg;
   logic        ram_we_reg;
   logic [7:0]  ram_addr_reg;
   logic [15:0] ram_wdata_reg;
   logic [15:0] rdata_reg;
   logic [2:0]  pick;

   always_comb begin
      pick = 3'b000;
      if (dbg_req)
         pick = 3'b100;
      else if (if_req && ls_req)
         pick = rr_ls_reg ? 3'b010 : 3'b001;
      else if (if_req)
         pick = 3'b001;
      else if (ls_req)
         pick = 3'b010;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         owner_reg     <= 3'b000;
         gnt_reg       <= 3'b000;
         rvalid_reg    <= 3'b000;
         rr_ls_reg     <= 1'b0;
         ram_en_reg    <= 1'b0;
         ram_we_reg    <= 1'b0;
         ram_addr_reg  <= 8'h00;
         ram_wdata_reg <= 16'h0000;
         rdata_reg     <= 16'h0000;
      end else begin
         gnt_reg    <= 3'b000;
         rvalid_reg <= 3'b000;
         ram_en_reg <= 1'b0;
         ram_we_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pick != 3'b000) begin
                  state_reg  <= ACCESS;
                  owner_reg  <= pick;
                  gnt_reg    <= pick;
                  ram_en_reg <= 1'b1;
                  if (pick[2]) begin
                     ram_we_reg    <= dbg_we;
                     ram_addr_reg  <= dbg_addr;
                     ram_wdata_reg <= dbg_wdata;
                  end else if (pick[1]) begin
                     ram_we_reg    <= ls_we;
                     ram_addr_reg  <= ls_addr;
                     ram_wdata_reg <= ls_wdata;
                     rr_ls_reg     <= 1'b0;
                  end else begin
                     ram_we_reg    <= 1'b0;
                     ram_addr_reg  <= if_addr;
                     rr_ls_reg     <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (ram_we_reg) begin
                  state_reg <= IDLE;
               end else begin
                  state_reg  <= READ;
                  rvalid_reg <= owner_reg;
               end
            end
            READ: begin
               rdata_reg <= ram_rdata;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // The RAM's own output register supplies the data during READ; the local
   // copy keeps it visible afterwards until the next read replaces it.
   assign rdata      = (state_reg == READ) ? ram_rdata : rdata_reg;
   assign if_gnt     = gnt_reg[0];
   assign ls_gnt     = gnt_reg[1];
   assign dbg_gnt    = gnt_reg[2];
   assign if_rvalid  = rvalid_reg[0];
   assign ls_rvalid  = rvalid_reg[1];
   assign dbg_rvalid = rvalid_reg[2];
   assign ram_en     = ram_en_reg;
   assign ram_we     = ram_we_reg;
   assign ram_addr   = ram_addr_reg;
   assign ram_wdata  = ram_wdata_reg;
   assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous RAM model and grant/read-data
// scoreboards filled by the stimulus and drained by a negedge monitor.
module tb_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [7:0]  if_addr;
   logic        ls_req;
   logic        ls_we;
   logic [7:0]  ls_addr;
   logic [15:0] ls_wdata;
   logic        dbg_req;
   logic        dbg_we;
   logic [7:0]  dbg_addr;
   logic [15:0] dbg_wdata;
   logic [15:0] ram_rdata;
   logic        if_gnt, ls_gnt, dbg_gnt;
   logic        if_rvalid, ls_rvalid, dbg_rvalid;
   logic [15:0] rdata;
   logic        ram_en, ram_we;
   logic [7:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic        busy;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .ram_rdata(ram_rdata),
      .if_gnt(if_gnt), .ls_gnt(ls_gnt), .dbg_gnt(dbg_gnt),
      .if_rvalid(if_rvalid), .ls_rvalid(ls_rvalid), .dbg_rvalid(dbg_rvalid),
      .rdata(rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  port;
      logic [15:0] data;
   } rv_t;

   int   errors = 0;
   int   checks = 0;
   int   gnt_q[$];
   rv_t  rv_q[$];

   function automatic logic [15:0] init_val(input int a);
      case (a)
         'h10:    return 16'hA5C3;
         'h30:    return 16'h3333;
         'h31:    return 16'h4444;
         'h40:    return 16'hBEEF;
         default: return {8'h5A, a[7:0]};
      endcase
   endfunction

   // Synchronous RAM: read data appears the cycle after the strobe.
   logic [15:0] mem [256];
   logic        mem_ready = 1'b0;
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
         mem_ready <= 1'b1;
         ram_rdata <= 16'h0000;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int port_of(input logic [2:0] v);
      if (v[2]) return 2;
      if (v[1]) return 1;
      return 0;
   endfunction

   logic [2:0] mon_gnt;
   logic [2:0] mon_rv;
   always @(negedge clk) begin
      mon_gnt = {dbg_gnt, ls_gnt, if_gnt};
      mon_rv  = {dbg_rvalid, ls_rvalid, if_rvalid};
      if (mon_gnt != 3'b000) begin
         chk("gnt_onehot", 32'($countones(mon_gnt)), 32'd1);
         if (gnt_q.size() == 0) begin
            chk("gnt_unexpected", 32'(mon_gnt), 32'd0);
         end else begin
            int e;
            e = gnt_q.pop_front();
            chk("gnt_order", 32'(port_of(mon_gnt)), 32'(e));
            $display("grant port=%0d expected=%0d t=%0t", port_of(mon_gnt), e, $time);
         end
      end
      if (mon_rv != 3'b000) begin
         chk("rvalid_onehot", 32'($countones(mon_rv)), 32'd1);
         if (rv_q.size() == 0) begin
            chk("rvalid_unexpected", 32'(mon_rv), 32'd0);
         end else begin
            rv_t e;
            e = rv_q.pop_front();
            chk("rvalid_port", 32'(port_of(mon_rv)), 32'(e.port));
            chk("rvalid_data", 32'(rdata), 32'(e.data));
            $display("rvalid port=%0d rdata=0x%04h expected=0x%04h t=%0t",
                     port_of(mon_rv), rdata, e.data, $time);
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1;
      if_req = 1'b0; if_addr = 8'h00;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = 8'h00; ls_wdata = 16'h0000;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 16'h0000;
      repeat (3) tick();

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gnt", 32'({dbg_gnt, ls_gnt, if_gnt}), 32'd0);
      chk("rst_rvalid", 32'({dbg_rvalid, ls_rvalid, if_rvalid}), 32'd0);
      chk("rst_ram_ctl", 32'({ram_en, ram_we}), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Single fetch
      if_req = 1'b1; if_addr = 8'h10;
      gnt_q.push_back(0); rv_q.push_back('{port: 2'd0, data: 16'hA5C3});
      tick();
      chk("fetch_gnt", 32'(if_gnt), 32'd1);
      chk("fetch_ram_en", 32'(ram_en), 32'd1);
      chk("fetch_ram_we", 32'(ram_we), 32'd0);
      chk("fetch_ram_addr", 32'(ram_addr), 32'h10);
      chk("fetch_busy_a", 32'(busy), 32'd1);
      if_req = 1'b0; if_addr = 8'hFF;
      tick();
      chk("fetch_rvalid", 32'(if_rvalid), 32'd1);
      chk("fetch_rdata", 32'(rdata), 32'hA5C3);
      chk("fetch_busy_r", 32'(busy), 32'd1);
      chk("fetch_ram_en_off", 32'(ram_en), 32'd0);
      tick();
      chk("fetch_idle", 32'(busy), 32'd0);
      chk("fetch_rdata_hold", 32'(rdata), 32'hA5C3);

      // Store, with fields changed right after selection
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h20; ls_wdata = 16'h1234;
      gnt_q.push_back(1);
      tick();
      chk("store_gnt", 32'(ls_gnt), 32'd1);
      chk("store_ram_we", 32'(ram_we), 32'd1);
      chk("store_wdata", 32'(ram_wdata), 32'h1234);
      chk("store_addr", 32'(ram_addr), 32'h20);
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = 8'h99; ls_wdata = 16'hFFFF;
      tick();
      chk("store_idle", 32'(busy), 32'd0);
      chk("store_no_rvalid", 32'(ls_rvalid), 32'd0);
      chk("store_ram_ctl_off", 32'({ram_en, ram_we}), 32'd0);
      chk("store_addr_hold", 32'(ram_addr), 32'h20);
      chk("store_wdata_hold", 32'(ram_wdata), 32'h1234);
      chk("store_mem", 32'(mem[8'h20]), 32'h1234);
      chk("store_mem_untouched", 32'(mem[8'h99]), 32'(init_val('h99)));

      // Debug read-back of the stored word
      dbg_req = 1'b1; dbg_addr = 8'h20;
      gnt_q.push_back(2); rv_q.push_back('{port: 2'd2, data: 16'h1234});
      tick();
      dbg_req = 1'b0;
      repeat (2) tick();

      // Contention right after reset: if, ls, if, ls, if, ls
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_rdata", 32'(rdata), 32'd0);
      if_req = 1'b1; if_addr = 8'h30;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h31;
      for (int k = 0; k < 6; k++) begin
         gnt_q.push_back(k % 2);
         rv_q.push_back('{port: 2'(k % 2), data: (k % 2 == 0) ? 16'h3333 : 16'h4444});
      end
      n = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         tick();
         if (if_gnt || ls_gnt) n++;
      end
      if_req = 1'b0; ls_req = 1'b0;
      chk("rr_grant_count", 32'(n), 32'd6);
      repeat (3) tick();

      // Move the pointer to favour ls, then verify debug does not disturb it
      if_req = 1'b1; if_addr = 8'h30;
      gnt_q.push_back(0); rv_q.push_back('{port: 2'd0, data: 16'h3333});
      tick();
      if_req = 1'b0;
      repeat (2) tick();
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h40;
      if_req = 1'b1; ls_req = 1'b1;
      gnt_q.push_back(2); rv_q.push_back('{port: 2'd2, data: 16'hBEEF});
      gnt_q.push_back(1); rv_q.push_back('{port: 2'd1, data: 16'h4444});
      gnt_q.push_back(0); rv_q.push_back('{port: 2'd0, data: 16'h3333});
      n = 0;
      for (int c = 0; c < 40 && n < 3; c++) begin
         tick();
         if (dbg_gnt) dbg_req = 1'b0;
         if (dbg_gnt || if_gnt || ls_gnt) n++;
      end
      if_req = 1'b0; ls_req = 1'b0; dbg_req = 1'b0;
      chk("dbg_grant_count", 32'(n), 32'd3);
      repeat (3) tick();

      // Reset in the ACCESS cycle of an ls read: access is abandoned
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h31;
      gnt_q.push_back(1);
      tick();
      chk("abort_gnt", 32'(ls_gnt), 32'd1);
      rst = 1'b1; ls_req = 1'b0;
      tick();
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_gnt_off", 32'({dbg_gnt, ls_gnt, if_gnt}), 32'd0);
      chk("abort_rvalid", 32'({dbg_rvalid, ls_rvalid, if_rvalid}), 32'd0);
      chk("abort_ram", 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'd0);
      chk("abort_rdata", 32'(rdata), 32'd0);
      rst = 1'b0;
      repeat (5) tick();

      chk("gnt_queue_empty", 32'(gnt_q.size()), 32'd0);
      chk("rvalid_queue_empty", 32'(rv_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
